// File: rtl/ms_share_arbiter.sv
// ms_share_arbiter: round-robin front end for one shared sequential
// shift-add multiplier. One job is in flight at a time. The winning
// requester's operands are registered and the multiplier is strobed. The
// block then waits out the minimum latency and returns the product tagged
// with the requester index. A watchdog produces an error response if the
// datapath never signals done.
//
// Handshake summary:
//   req/ack    : a requester holds req until it sees the single-cycle ack
//                pulse. The ack marks the cycle its operands were captured.
//   rsp_valid/rsp_ready : the response is held stable while
//                rsp_valid && !rsp_ready, and it retires on the first clock
//                edge with both signals high.
//
// Counter convention: in BUSY, cnt_inc is the number of BUSY cycles elapsed,
// including the current one. The multiplier's done is accepted once
// cnt_inc >= LAT. The watchdog fires when cnt_inc reaches TIMEOUT.
// With mul_done already high, the response appears LAT+1 edges after the
// granting edge. The issue interval is LAT+3 cycles.
module ms_share_arbiter #(
  parameter int DW      = 8,
  parameter int DW_2    = 2 * DW,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int LAT     = DW + 1,
  parameter int TIMEOUT = 4 * DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] op_a,
  input  logic [NREQ*DW-1:0] op_b,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [DW_2-1:0]   rsp_product,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_ls,
  output logic [DW-1:0]     mul_a,
  output logic [DW-1:0]     mul_b,
  input  logic              mul_done,
  input  logic [DW_2-1:0]   mul_product,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BUSY = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              mul_ls_q, mul_ls_d;
  logic [DW-1:0]     mul_a_q, mul_a_d;
  logic [DW-1:0]     mul_b_q, mul_b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW_2-1:0]   rsp_product_q, rsp_product_d;
  logic              rsp_err_q, rsp_err_d;

  logic              gnt_found;
  logic [IDW-1:0]    gnt_id;
  int                idx;

  // Round-robin pick: first requester after the last winner, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[IDW-1:0];
      end
    end
  end

  // Next-state and registered-output logic for the job FSM.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    ack_d         = '0;
    mul_ls_d      = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          state_d         = S_LOAD;
          ptr_d           = gnt_id;
          id_d            = gnt_id;
          ack_d[gnt_id]   = 1'b1;
          mul_ls_d        = 1'b1;   // high for the whole LOAD cycle
          mul_a_d         = op_a[gnt_id*DW +: DW];
          mul_b_d         = op_b[gnt_id*DW +: DW];
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_inc;
        // A done seen before LAT cycles may be left over from the last job.
        if ((cnt_inc >= CW'(LAT)) && mul_done) begin
          rsp_product_d = mul_product;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= IDW'(NREQ - 1);
      id_q          <= '0;
      ack_q         <= '0;
      mul_ls_q      <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      ack_q         <= ack_d;
      mul_ls_q      <= mul_ls_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign ack         = ack_q;
  assign mul_ls      = mul_ls_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_product = rsp_product_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ms_share_arbiter.sv
// Directed bench for ms_share_arbiter with a behavioural multiplier model
// and a response scoreboard keyed by {id, product, err}.
module tb_ms_share_arbiter;

  localparam int DW      = 8;
  localparam int DW_2    = 16;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int LAT     = DW + 1;
  localparam int TIMEOUT = 4 * DW;
  localparam int W       = IDW + DW_2 + 1;
  localparam int MUL_DELAY = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] op_a, op_b;
  logic [NREQ-1:0]    ack;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW_2-1:0]    rsp_product;
  logic               rsp_err, busy, mul_ls;
  logic [DW-1:0]      mul_a, mul_b;
  logic               mul_done;
  logic [DW_2-1:0]    mul_product;
  logic [1:0]         dbg_state;

  ms_share_arbiter #(.DW(DW), .DW_2(DW_2), .NREQ(NREQ), .IDW(IDW),
                     .LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy),
    .mul_ls(mul_ls), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_product(mul_product), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [DW_2-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW_2-1:0] sa, sb;
    sa = {{DW{a[DW-1]}}, a};
    sb = {{DW{b[DW-1]}}, b};
    return sa * sb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- multiplier model ----------------
  // mode 0: done rises MUL_DELAY cycles after the load strobe and stays high.
  // mode 1: done stuck high. mode 2: done stuck low.
  logic [1:0]      mul_mode;
  int              mul_wait;
  logic            mul_done_n;
  logic [DW_2-1:0] mul_prod_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_wait   <= 0;
      mul_done_n <= 1'b0;
      mul_prod_q <= '0;
    end else if (mul_ls) begin
      mul_wait   <= MUL_DELAY;
      mul_done_n <= 1'b0;
    end else if (mul_wait > 1) begin
      mul_wait   <= mul_wait - 1;
    end else if (mul_wait == 1) begin
      mul_wait   <= 0;
      mul_done_n <= 1'b1;
      mul_prod_q <= smul(mul_a, mul_b);
    end
  end
  assign mul_done    = (mul_mode == 2'd1) ? 1'b1 : (mul_mode == 2'd2) ? 1'b0 : mul_done_n;
  assign mul_product = mul_prod_q;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow observed=%0h expected=none", {rsp_id, rsp_product, rsp_err});
      end
      if (exp_q.size() != 0)
        check("sb_rsp", 32'({rsp_id, rsp_product, rsp_err}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_a[id*DW +: DW] = a;
    op_b[id*DW +: DW] = b;
  endtask

  task automatic push_exp(input int id, input logic [DW_2-1:0] p, input logic e);
    exp_q.push_back({id[IDW-1:0], p, e});
  endtask

  task automatic wait_ack(input logic [NREQ-1:0] expv, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 200);
    check(tag, 32'(ack), 32'(expv));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Single job with rsp_ready high, checked edge by edge from the grant.
  task automatic timed_job(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int rsp_edge, input logic err);
    logic early;
    set_ops(id, a, b);
    req = '0;
    req[id] = 1'b1;
    push_exp(id, err ? '0 : smul(a, b), err);
    tick();                                   // edge 0
    check("ack_grant", 32'(ack), 32'(req));
    check("mul_ls_on", 32'(mul_ls), 32'd1);
    check("mul_a", 32'(mul_a), 32'(a));
    check("mul_b", 32'(mul_b), 32'(b));
    check("busy_on", 32'(busy), 32'd1);
    req = '0;
    tick();                                   // edge 1
    check("mul_ls_off", 32'(mul_ls), 32'd0);
    check("ack_off", 32'(ack), 32'd0);
    early = 1'b0;
    for (int e = 2; e < rsp_edge; e++) begin
      tick();
      if (rsp_valid) early = 1'b1;
    end
    check("no_early_rsp", 32'(early), 32'd0);
    tick();                                   // response edge
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_id", 32'(rsp_id), 32'(id));
    tick();
    check("rsp_clear", 32'(rsp_valid), 32'd0);
    check("busy_off", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mul_ls"}, 32'(mul_ls), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_product"}, 32'(rsp_product), 32'd0);
    check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] ta[NREQ];
    logic [DW-1:0] tbv[NREQ];
    int order[5];
    int n;

    rst = 1'b1; req = '0; op_a = '0; op_b = '0; rsp_ready = 1'b1; mul_mode = 2'd0;
    tick();
    check_all_zero("reset");
    do_reset();

    // T1: single request, nominal latency
    timed_job(0, 8'd3, 8'd5, LAT + 1, 1'b0);
    drain("t1_drain");

    // T2: all four held after reset -> 0,1,2,3,0
    do_reset();
    ta[0] = 8'hFD; tbv[0] = 8'd7;      // -3 * 7
    ta[1] = 8'd127; tbv[1] = 8'hFF;    // 127 * -1
    ta[2] = 8'h80; tbv[2] = 8'h80;     // -128 * -128
    ta[3] = 8'd11; tbv[3] = 8'd0;
    for (int i = 0; i < NREQ; i++) set_ops(i, ta[i], tbv[i]);
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    for (int k = 0; k < 5; k++) push_exp(order[k], smul(ta[order[k]], tbv[order[k]]), 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(4'b0001 << order[k], "t2_grant_order");
    end
    req = '0;
    drain("t2_drain");

    // T3: done stuck high from reset; capture must wait for LAT
    mul_mode = 2'd1;
    do_reset();
    timed_job(2, 8'hFB, 8'd9, LAT + 1, 1'b0);

    // T4: done stuck low -> watchdog error, then a normal job
    mul_mode = 2'd2;
    timed_job(1, 8'd12, 8'd12, TIMEOUT + 1, 1'b1);
    mul_mode = 2'd0;
    timed_job(3, 8'hFF, 8'hFF, LAT + 1, 1'b0);
    drain("t4_drain");

    // T5: response back-pressure, no new grant while held
    rsp_ready = 1'b0;
    set_ops(2, 8'd20, 8'hFD);
    push_exp(2, smul(8'd20, 8'hFD), 1'b0);
    req = 4'b0100;
    wait_ack(4'b0100, "t5_ack");
    req = '0;
    n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    check("t5_valid", 32'(rsp_valid), 32'd1);
    set_ops(0, 8'd9, 8'd9);
    push_exp(0, smul(8'd9, 8'd9), 1'b0);
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_id", 32'(rsp_id), 32'd2);
      check("t5_hold_product", 32'(rsp_product), 32'(smul(8'd20, 8'hFD)));
      check("t5_hold_noack", 32'(ack), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_ack(4'b0001, "t5_ack_after");
    req = '0;
    drain("t5_drain");

    // T6: reset in BUSY drops the job
    set_ops(1, 8'd50, 8'd2);
    req = 4'b0010;
    wait_ack(4'b0010, "t6_ack_first");
    req = '0;
    tick(); tick(); tick();
    check("t6_in_busy", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    exp_q.delete();
    tick();
    rst = 1'b0;
    set_ops(1, 8'hEC, 8'd6);
    push_exp(1, smul(8'hEC, 8'd6), 1'b0);
    req = 4'b0010;
    wait_ack(4'b0010, "t6_ack_after");
    req = '0;
    drain("t6_drain");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
